// File: rtl/ddr_rd_port_arbiter.sv
// rtl/ddr_rd_port_arbiter.sv - round-robin arbiter sharing one DDR AXI read port among NUM_REQ masters
module ddr_rd_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  input  logic [NUM_REQ-1:0]     req_arvalid,
  input  logic [32*NUM_REQ-1:0]  req_araddr,
  input  logic [4*NUM_REQ-1:0]   req_arlen,
  output logic [NUM_REQ-1:0]     req_arready,
  output logic [255:0]           req_rdata,
  output logic [NUM_REQ-1:0]     req_rvalid,
  output logic [NUM_REQ-1:0]     req_rlast,
  output logic [31:0]            axi_araddr,
  output logic [3:0]             axi_aruser_id,
  output logic [3:0]             axi_arlen,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [255:0]           axi_rdata,
  input  logic                   axi_rvalid,
  input  logic                   axi_rlast,
  input  logic [3:0]             axi_rid,
  output logic [3:0]             outstanding,
  output logic                   rid_err
);

  typedef enum logic {IDLE, ADDR} state_t;

  state_t      state, state_next;
  logic [1:0]  ptr, ptr_next, pick;
  logic        found, grant, ar_hs, rid_ok, dec_req, dec_ok;
  logic [31:0] sel_addr;
  logic [3:0]  sel_len;

  // Two passes: requesters at or above the pointer first, then the wrapped-around ones.
  always_comb begin
    found    = 1'b0;
    pick     = 2'd0;
    sel_addr = 32'd0;
    sel_len  = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_arvalid[i] && (i >= int'(ptr))) begin
        found    = 1'b1;
        pick     = 2'(i);
        sel_addr = req_araddr[32*i +: 32];
        sel_len  = req_arlen[4*i +: 4];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_arvalid[i] && (i < int'(ptr))) begin
        found    = 1'b1;
        pick     = 2'(i);
        sel_addr = req_araddr[32*i +: 32];
        sel_len  = req_arlen[4*i +: 4];
      end
    end
  end

  assign axi_arvalid = (state == ADDR);
  assign ar_hs       = axi_arvalid && axi_arready;
  assign grant       = (state == IDLE) && found && (outstanding < 4'(MAX_OUTSTANDING));
  assign rid_ok      = (axi_rid < 4'(NUM_REQ));
  assign dec_req     = axi_rvalid && axi_rlast && rid_ok;
  // A completion with nothing outstanding (e.g. stale beats after reset) is not counted.
  assign dec_ok      = dec_req && (outstanding != 4'd0);
  assign ptr_next    = (axi_aruser_id[1:0] == 2'(NUM_REQ-1)) ? 2'd0 : axi_aruser_id[1:0] + 2'd1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ADDR;
      ADDR:    if (axi_arready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      axi_araddr    <= 32'd0;
      axi_arlen     <= 4'd0;
      axi_aruser_id <= 4'd0;
      req_arready   <= '0;
      req_rdata     <= 256'd0;
      req_rvalid    <= '0;
      req_rlast     <= '0;
      outstanding   <= 4'd0;
      rid_err       <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        axi_araddr    <= sel_addr;
        axi_arlen     <= sel_len;
        axi_aruser_id <= {2'b00, pick};
      end
      if (ar_hs) ptr <= ptr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_arready[i] <= ar_hs && (axi_aruser_id == 4'(i));
        req_rvalid[i]  <= axi_rvalid && (axi_rid == 4'(i));
        req_rlast[i]   <= axi_rvalid && axi_rlast && (axi_rid == 4'(i));
      end
      case ({ar_hs, dec_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
      if (axi_rvalid) req_rdata <= axi_rdata;
      if ((axi_rvalid && !rid_ok) || (dec_req && !dec_ok)) rid_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_rd_port_arbiter.sv
// tb/tb_ddr_rd_port_arbiter.sv - self-checking bench for ddr_rd_port_arbiter
module tb_ddr_rd_port_arbiter;
  localparam int N    = 2;
  localparam int MAXO = 4;

  logic           clk = 1'b0;
  logic           axi_rst;
  logic [N-1:0]   req_arvalid;
  logic [32*N-1:0] req_araddr;
  logic [4*N-1:0] req_arlen;
  logic [N-1:0]   req_arready;
  logic [255:0]   req_rdata;
  logic [N-1:0]   req_rvalid, req_rlast;
  logic [31:0]    axi_araddr;
  logic [3:0]     axi_aruser_id, axi_arlen;
  logic           axi_arvalid, axi_arready;
  logic [255:0]   axi_rdata;
  logic           axi_rvalid, axi_rlast;
  logic [3:0]     axi_rid;
  logic [3:0]     outstanding;
  logic           rid_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_rd_port_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .axi_clk(clk), .axi_rst(axi_rst),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready), .req_rdata(req_rdata), .req_rvalid(req_rvalid), .req_rlast(req_rlast),
    .axi_araddr(axi_araddr), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata),
    .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
    .outstanding(outstanding), .rid_err(rid_err)
  );

  typedef struct {
    logic         rv;
    logic         rl;
    logic [3:0]   rid;
    logic [255:0] rd;
    logic [1:0]   e_rv;
    logic [1:0]   e_rl;
    logic         e_err;
  } rvec_t;

  rvec_t tbl[5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    axi_rst = 1'b1;
    req_arvalid = '0; req_araddr = '0; req_arlen = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rid = 4'd0; axi_rdata = '0;
    tick();
    tick();
    axi_rst = 1'b0;
  endtask

  // First requester at or after the round-robin pointer, wrapping; -1 if none.
  function automatic int winner(input logic [N-1:0] v, input int p);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  logic [N-1:0]    pre_req;
  logic            pre_av, pre_ar, pre_rv, pre_rl, hs, exp_av;
  logic [3:0]      pre_user, pre_arlen, pre_rid;
  logic [31:0]     pre_araddr;
  logic [32*N-1:0] pre_reqaddr;
  logic [4*N-1:0]  pre_reqlen;
  logic [255:0]    pre_rd;
  int              mcnt, mptr, cnt0, w;

  initial begin
    tbl[0] = '{1'b0, 1'b0, 4'd0, 256'd0,           2'b00, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'd0, {8{32'h1111_0000}}, 2'b01, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'd1, {8{32'h2222_0001}}, 2'b10, 2'b00, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 4'd1, {8{32'h3333_0002}}, 2'b00, 2'b00, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'd1, {8{32'h4444_0003}}, 2'b10, 2'b10, 1'b1};

    // Reset with both requests pending
    do_reset();
    axi_rst = 1'b1;
    req_arvalid = 2'b11;
    axi_arready = 1'b1;
    repeat (3) tick();
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_arready", req_arready, 0);
    chk("rst_rvalid", req_rvalid, 0);
    chk("rst_rlast", req_rlast, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_rid_err", rid_err, 0);
    chk("rst_araddr", axi_araddr, 0);
    axi_rst = 1'b0;
    req_arvalid = 2'b00;
    tick();

    // Single request, single beat
    req_araddr[31:0] = 32'h0000_1000;
    req_arlen[3:0] = 4'd0;
    req_arvalid = 2'b01;
    tick();
    chk("single_arvalid", axi_arvalid, 1);
    chk("single_id", axi_aruser_id, 0);
    chk("single_addr", axi_araddr, 32'h0000_1000);
    chk("single_arready_early", req_arready, 0);
    tick();
    chk("single_arready", req_arready, 2'b01);
    chk("single_arvalid_drop", axi_arvalid, 0);
    chk("single_outstanding", outstanding, 1);
    req_arvalid = 2'b00;
    axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rid = 4'd0; axi_rdata = {32{8'hA5}};
    tick();
    chk("single_rvalid", req_rvalid, 2'b01);
    chk("single_rlast", req_rlast, 2'b01);
    chk("single_rdata", req_rdata, {32{8'hA5}});
    chk("single_out_done", outstanding, 0);
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    tick();
    chk("single_rvalid_clear", req_rvalid, 0);

    // R routing vectors (outstanding is 0 here)
    for (int i = 0; i < 5; i++) begin
      axi_rvalid = tbl[i].rv; axi_rlast = tbl[i].rl; axi_rid = tbl[i].rid; axi_rdata = tbl[i].rd;
      tick();
      chk($sformatf("tbl%0d_rvalid", i), req_rvalid, tbl[i].e_rv);
      chk($sformatf("tbl%0d_rlast", i), req_rlast, tbl[i].e_rl);
      chk($sformatf("tbl%0d_rid_err", i), rid_err, tbl[i].e_err);
      chk($sformatf("tbl%0d_outstanding", i), outstanding, 0);
      if (tbl[i].rv) chk($sformatf("tbl%0d_rdata", i), req_rdata, tbl[i].rd);
    end

    // Round-robin to the outstanding limit, then release one slot
    do_reset();
    req_araddr = {32'h0000_0200, 32'h0000_0100};
    req_arlen = {4'd7, 4'd3};
    req_arvalid = 2'b11;
    axi_arready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d_arvalid", k), axi_arvalid, 1);
      chk($sformatf("rr%0d_id", k), axi_aruser_id, k % 2);
      chk($sformatf("rr%0d_addr", k), axi_araddr, (k % 2) ? 32'h200 : 32'h100);
      chk($sformatf("rr%0d_len", k), axi_arlen, (k % 2) ? 7 : 3);
      tick();
      chk($sformatf("rr%0d_arready", k), req_arready, (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("rr%0d_outstanding", k), outstanding, k + 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("limit_arvalid", axi_arvalid, 0);
      chk("limit_outstanding", outstanding, 4);
    end
    axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rid = 4'd1;
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    chk("release_outstanding", outstanding, 3);
    chk("release_rlast", req_rlast, 2'b10);
    chk("release_arvalid", axi_arvalid, 0);
    tick();
    chk("fifth_arvalid", axi_arvalid, 1);
    chk("fifth_id", axi_aruser_id, 0);
    tick();
    chk("fifth_arready", req_arready, 2'b01);
    chk("fifth_outstanding", outstanding, 4);

    // AR backpressure
    do_reset();
    req_araddr[63:32] = 32'hDEAD_BEE0;
    req_arlen[7:4] = 4'd5;
    req_arvalid = 2'b10;
    tick();
    chk("bp_arvalid", axi_arvalid, 1);
    req_araddr[31:0] = 32'h0000_4440;
    req_arvalid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_arvalid", axi_arvalid, 1);
      chk("bp_hold_addr", axi_araddr, 32'hDEAD_BEE0);
      chk("bp_hold_len", axi_arlen, 5);
      chk("bp_hold_id", axi_aruser_id, 1);
      chk("bp_no_arready", req_arready, 0);
    end
    axi_arready = 1'b1;
    tick();
    chk("bp_arready", req_arready, 2'b10);
    chk("bp_outstanding", outstanding, 1);
    req_arvalid = 2'b00;
    axi_arready = 1'b0;

    // Out-of-range rid
    axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rid = 4'd3; axi_rdata = {8{32'hBAD0_0BAD}};
    tick();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    chk("badrid_rvalid", req_rvalid, 0);
    chk("badrid_rlast", req_rlast, 0);
    chk("badrid_err", rid_err, 1);
    chk("badrid_outstanding", outstanding, 1);
    tick();
    tick();
    chk("badrid_sticky", rid_err, 1);

    // Randomized traffic against a transaction-level model
    do_reset();
    mcnt = 0;
    mptr = 0;
    for (int c = 0; c < 800; c++) begin
      pre_req = req_arvalid; pre_av = axi_arvalid; pre_ar = axi_arready; pre_user = axi_aruser_id;
      pre_araddr = axi_araddr; pre_arlen = axi_arlen; pre_reqaddr = req_araddr; pre_reqlen = req_arlen;
      pre_rv = axi_rvalid; pre_rl = axi_rlast; pre_rid = axi_rid; pre_rd = axi_rdata;
      cnt0 = mcnt;
      tick();
      hs = pre_av && pre_ar;
      exp_av = pre_av ? !pre_ar : ((pre_req != 0) && (cnt0 < MAXO));
      chk("rnd_arvalid", axi_arvalid, exp_av);
      if (!pre_av && axi_arvalid) begin
        w = winner(pre_req, mptr);
        chk("rnd_grant_id", axi_aruser_id, w);
        if (w >= 0) begin
          chk("rnd_grant_addr", axi_araddr, pre_reqaddr[32*w +: 32]);
          chk("rnd_grant_len", axi_arlen, pre_reqlen[4*w +: 4]);
        end
      end else if (pre_av && axi_arvalid) begin
        chk("rnd_hold_addr", axi_araddr, pre_araddr);
        chk("rnd_hold_len", axi_arlen, pre_arlen);
        chk("rnd_hold_id", axi_aruser_id, pre_user);
      end
      if (hs) mptr = (int'(pre_user) + 1) % N;
      chk("rnd_arready", req_arready, hs ? (256'd1 << pre_user) : 256'd0);
      mcnt = cnt0 + (hs ? 1 : 0) - ((pre_rv && pre_rl && pre_rid < N && cnt0 > 0) ? 1 : 0);
      chk("rnd_outstanding", outstanding, mcnt);
      chk("rnd_rvalid", req_rvalid, pre_rv ? (256'd1 << pre_rid) : 256'd0);
      chk("rnd_rlast", req_rlast, (pre_rv && pre_rl) ? (256'd1 << pre_rid) : 256'd0);
      if (pre_rv) chk("rnd_rdata", req_rdata, pre_rd);
      chk("rnd_rid_err", rid_err, 0);
      for (int i = 0; i < N; i++) begin
        if (!req_arvalid[i] || req_arready[i]) begin
          req_arvalid[i] = ($urandom % 3) != 0;
          req_araddr[32*i +: 32] = $urandom;
          req_arlen[4*i +: 4] = 4'($urandom);
        end
      end
      axi_arready = ($urandom % 4) != 0;
      axi_rvalid = 1'($urandom);
      axi_rid = 4'($urandom % N);
      axi_rlast = (mcnt > 0) && (($urandom % 3) == 0);
      axi_rdata = {8{$urandom}};
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
